// File: rtl/huff_pkg.sv
// Shared types and constants for the Huffman code serializer.
package huff_pkg;
  localparam int DEF_MAX_SYM   = 255;
  localparam int DEF_BIT_WIDTH = 8;
  localparam int DEF_CODE_LEN  = 16;
  localparam int DEF_LEN_WIDTH = 5;
  localparam int MAX_TEXT      = 1024;
  localparam int TOTAL_W       = 11;

  typedef enum logic [1:0] {IDLE, LOOKUP, SHIFT, FINISH} ser_state_e;
endpackage

// File: rtl/code_table.sv
// Symbol-indexed {len, code} table: sync write, registered read,
// length fields cleared on reset so every symbol starts out unused.
module code_table
  import huff_pkg::*;
#(
  parameter int MAX_SYM   = DEF_MAX_SYM,
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int CODE_LEN  = DEF_CODE_LEN,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [BIT_WIDTH-1:0] wr_addr_i,
  input  logic [CODE_LEN-1:0]  wr_code_i,
  input  logic [LEN_WIDTH-1:0] wr_len_i,
  input  logic                 rd_en_i,
  input  logic [BIT_WIDTH-1:0] rd_addr_i,
  output logic [CODE_LEN-1:0]  rd_code_o,
  output logic [LEN_WIDTH-1:0] rd_len_o
);
  logic [LEN_WIDTH-1:0] len_mem  [MAX_SYM+1];
  logic [CODE_LEN-1:0]  code_mem [MAX_SYM+1];
  logic [LEN_WIDTH-1:0] rd_len_d,  rd_len_q;
  logic [CODE_LEN-1:0]  rd_code_d, rd_code_q;

  // Length fields: cleared on reset, written on demand.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i <= MAX_SYM; i++) len_mem[i] <= '0;
    end else if (we_i) begin
      len_mem[wr_addr_i] <= wr_len_i;
    end
  end

  // Code fields carry no reset; a zero length makes them irrelevant.
  always_ff @(posedge clk_i) begin
    if (we_i) code_mem[wr_addr_i] <= wr_code_i;
  end

  // Read port holds its data until the next read is issued.
  always_comb begin
    rd_len_d  = rd_len_q;
    rd_code_d = rd_code_q;
    if (rd_en_i) begin
      rd_len_d  = len_mem[rd_addr_i];
      rd_code_d = code_mem[rd_addr_i];
    end
  end

  // Registered read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_len_q  <= '0;
      rd_code_q <= '0;
    end else begin
      rd_len_q  <= rd_len_d;
      rd_code_q <= rd_code_d;
    end
  end

  assign rd_code_o = rd_code_q;
  assign rd_len_o  = rd_len_q;
endmodule

// File: rtl/code_serializer.sv
// Symbol -> Huffman codeword lookup, emitted MSB-first one bit per cycle,
// with a held finish flag and a saturating bit budget.
module code_serializer
  import huff_pkg::*;
#(
  parameter int MAX_SYM   = DEF_MAX_SYM,
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int CODE_LEN  = DEF_CODE_LEN,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 tbl_we_i,
  input  logic [BIT_WIDTH-1:0] tbl_addr_i,
  input  logic [CODE_LEN-1:0]  tbl_code_i,
  input  logic [LEN_WIDTH-1:0] tbl_len_i,
  input  logic                 sym_valid_i,
  output logic                 sym_ready_o,
  input  logic [BIT_WIDTH-1:0] sym_i,
  input  logic                 sym_last_i,
  output logic                 bit_o,
  output logic                 bit_valid_o,
  output logic                 finish_o,
  output logic [TOTAL_W-1:0]   total_bit_o,
  output logic                 overflow_o,
  output logic                 error_o
);
  localparam logic [TOTAL_W-1:0]   BUDGET  = TOTAL_W'(MAX_TEXT);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(CODE_LEN);

  ser_state_e           state_d, state_q;
  logic [CODE_LEN-1:0]  shreg_d, shreg_q;
  logic [LEN_WIDTH-1:0] cnt_d, cnt_q;
  logic [TOTAL_W-1:0]   total_d, total_q;
  logic                 ovf_d, ovf_q, err_d, err_q, last_d, last_q;
  logic                 rd_en, tbl_we;
  logic [LEN_WIDTH-1:0] wr_len, rd_len, shamt;
  logic [CODE_LEN-1:0]  rd_code;

  // Table is only writable while no lookup/shift is in flight.
  assign tbl_we = tbl_we_i && (state_q == IDLE || state_q == FINISH);
  assign wr_len = (tbl_len_i > LEN_MAX) ? LEN_MAX : tbl_len_i;

  code_table #(
    .MAX_SYM(MAX_SYM), .BIT_WIDTH(BIT_WIDTH),
    .CODE_LEN(CODE_LEN), .LEN_WIDTH(LEN_WIDTH)
  ) u_table (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (tbl_we),
    .wr_addr_i (tbl_addr_i),
    .wr_code_i (tbl_code_i),
    .wr_len_i  (wr_len),
    .rd_en_i   (rd_en),
    .rd_addr_i (sym_i),
    .rd_code_o (rd_code),
    .rd_len_o  (rd_len)
  );

  // Codeword is left-aligned on load so the current bit (code[cnt-1])
  // always sits at the shift register MSB and unused high bits fall off.
  assign shamt = LEN_MAX - rd_len;

  // Next-state: handshake, lookup, shift with budget, clear override.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    last_d  = last_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sym_valid_i) begin
          last_d  = sym_last_i;
          rd_en   = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        shreg_d = rd_code << shamt;
        cnt_d   = rd_len;
        if (rd_len == '0) begin
          err_d   = 1'b1;
          state_d = last_q ? FINISH : IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - LEN_WIDTH'(1);
        if (total_q == BUDGET) ovf_d = 1'b1;
        else                   total_d = total_q + TOTAL_W'(1);
        if (cnt_q == LEN_WIDTH'(1)) state_d = last_q ? FINISH : IDLE;
      end
      default: ;
    endcase
    if (clear_i) begin
      state_d = IDLE;
      total_d = '0;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
      rd_en   = 1'b0;
    end
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  assign sym_ready_o = (state_q == IDLE);
  assign bit_valid_o = (state_q == SHIFT) && (total_q != BUDGET);
  assign bit_o       = (state_q == SHIFT) && shreg_q[CODE_LEN-1];
  assign finish_o    = (state_q == FINISH);
  assign total_bit_o = total_q;
  assign overflow_o  = ovf_q;
  assign error_o     = err_q;
endmodule

// File: tb/tb_code_serializer.sv
// Randomized bench for code_serializer with a cycle-scheduled stream model.
module tb_code_serializer;
  import huff_pkg::*;

  localparam int INF = 1 << 30;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1, clear_i = 1'b0, tbl_we_i = 1'b0;
  logic [7:0]  tbl_addr_i = '0, sym_i = '0;
  logic [15:0] tbl_code_i = '0;
  logic [4:0]  tbl_len_i = '0;
  logic        sym_valid_i = 1'b0, sym_last_i = 1'b0;
  logic        sym_ready_o, bit_o, bit_valid_o, finish_o, overflow_o, error_o;
  logic [10:0] total_bit_o;

  always #5 clk_i = ~clk_i;

  code_serializer dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .tbl_we_i(tbl_we_i), .tbl_addr_i(tbl_addr_i), .tbl_code_i(tbl_code_i),
    .tbl_len_i(tbl_len_i), .sym_valid_i(sym_valid_i), .sym_ready_o(sym_ready_o),
    .sym_i(sym_i), .sym_last_i(sym_last_i), .bit_o(bit_o),
    .bit_valid_o(bit_valid_o), .finish_o(finish_o), .total_bit_o(total_bit_o),
    .overflow_o(overflow_o), .error_o(error_o)
  );

  int checks = 0, passed = 0;

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // ---------------- model ----------------
  int tlen[256], tcode[256];
  int cyc = 0;
  bit sched_b[int];     // cycle -> bit the stream should carry
  int ready_at, err_at, fin_at, ovf_at, tot_m, strobes;
  int obs_q[$];
  bit chk_en = 1'b0;

  always @(posedge clk_i) cyc++;

  function automatic void model_clear(bit wipe_tbl);
    sched_b.delete();
    ready_at = 0; err_at = INF; fin_at = INF; ovf_at = INF;
    tot_m = 0; strobes = 0;
    obs_q.delete();
    if (wipe_tbl) for (int i = 0; i < 256; i++) tlen[i] = 0;
  endfunction

  // Symbol accepted on edge number a.
  function automatic void model_accept(int a, int sym, bit last);
    int len = tlen[sym];
    for (int i = 0; i < len; i++) sched_b[a + 1 + i] = 1'((tcode[sym] >> (len - 1 - i)) & 1);
    if (len == 0 && err_at > a + 1) err_at = a + 1;
    if (last) begin fin_at = a + 1 + len; ready_at = INF; end
    else ready_at = a + 1 + len;
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk_i) begin
    if (chk_en) begin
      bit ev;
      ev = sched_b.exists(cyc);
      chk("total", int'(total_bit_o), tot_m);
      chk("ready", int'(sym_ready_o), int'(cyc >= ready_at));
      chk("finish", int'(finish_o), int'(cyc >= fin_at));
      chk("error", int'(error_o), int'(cyc >= err_at));
      chk("overflow", int'(overflow_o), int'(cyc >= ovf_at));
      if (ev && tot_m < MAX_TEXT) begin
        chk("strobe", int'(bit_valid_o), 1);
        if (bit_valid_o) chk("bit", int'(bit_o), int'(sched_b[cyc]));
        tot_m++;
      end else begin
        chk("strobe", int'(bit_valid_o), 0);
        if (ev && ovf_at == INF) ovf_at = cyc + 1;
      end
      if (bit_valid_o) begin strobes++; obs_q.push_back(int'(bit_o)); end
      if (ev) sched_b.delete(cyc);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic twrite(int a, int code, int len);
    tbl_we_i = 1'b1; tbl_addr_i = 8'(a); tbl_code_i = 16'(code); tbl_len_i = 5'(len);
    tick();
    tbl_we_i = 1'b0;
    tlen[a] = (len > 16) ? 16 : len;
    tcode[a] = code & 'hFFFF;
  endtask

  task automatic send(int sym, bit last, bit hold);
    bit ok = 1'b0;
    sym_i = 8'(sym); sym_last_i = last; sym_valid_i = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_i);
      if (sym_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("handshake_timeout", 0, 1);
      sym_valid_i = 1'b0;
      return;
    end
    tick();
    model_accept(cyc, sym, last);
    if (!hold) sym_valid_i = 1'b0;
  endtask

  task automatic wait_fin(int maxc);
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk_i);
      if (finish_o) return;
    end
    chk("finish_timeout", 0, 1);
  endtask

  task automatic clr();
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    model_clear(1'b0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    model_clear(1'b1);
  endtask

  // Observed stream vs a hand-written bit pattern (n bits, MSB first).
  task automatic chk_stream(string name, int n, logic [31:0] bits);
    chk({name, "_len"}, obs_q.size(), n);
    for (int i = 0; i < n && i < obs_q.size(); i++)
      chk({name, "_bit"}, obs_q[i], int'(bits[n - 1 - i]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, sum, s, l;
    bit h;
    tick(); tick();
    model_clear(1'b1);
    chk_en = 1'b1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready", int'(sym_ready_o), 1);
    chk("rst_total", int'(total_bit_o), 0);
    chk("rst_finish", int'(finish_o), 0);
    chk("rst_valid", int'(bit_valid_o), 0);

    // Single 3-bit code.
    twrite('h41, 'b101, 3);
    send('h41, 1'b1, 1'b0);
    wait_fin(100);
    chk_stream("t1", 3, 32'b101);
    chk("t1_total", int'(total_bit_o), 3);
    chk("t1_finish", int'(finish_o), 1);

    // Clear from FINISH keeps the table.
    clr();
    send('h41, 1'b1, 1'b0);
    wait_fin(100);
    chk_stream("t6", 3, 32'b101);
    chk("t6_total", int'(total_bit_o), 3);

    // Back-to-back with valid held.
    clr();
    twrite('h41, 0, 1);
    twrite('h42, 'b11, 2);
    send('h41, 1'b0, 1'b1);
    send('h42, 1'b0, 1'b1);
    send('h41, 1'b1, 1'b0);
    wait_fin(100);
    chk_stream("t2", 4, 32'b0110);
    chk("t2_total", int'(total_bit_o), 4);

    // Unused symbol then a valid one.
    clr();
    send('h7F, 1'b0, 1'b0);
    send('h42, 1'b1, 1'b0);
    wait_fin(100);
    chk("t4_error", int'(error_o), 1);
    chk_stream("t4", 2, 32'b11);

    // Random messages over a random table (lengths 0..20, clamped to 16).
    for (int m = 0; m < 4; m++) begin
      clr();
      for (int i = 0; i < 8; i++) twrite('h10 + i, int'($urandom), int'($urandom_range(0, 20)));
      n = int'($urandom_range(5, 15));
      sum = 0;
      for (int i = 0; i < n; i++) begin
        s = 'h10 + int'($urandom_range(0, 7));
        l = tlen[s];
        sum += l;
        h = 1'($urandom_range(0, 1));
        send(s, i == n - 1, h && (i != n - 1));
        if (!h) repeat (int'($urandom_range(0, 2))) tick();
      end
      wait_fin(600);
      chk("rand_total", int'(total_bit_o), sum);
      chk("rand_strobes", strobes, sum);
    end

    // Budget overflow: 1023 bits, then a 16-bit code.
    clr();
    twrite('h00, 'hFFFF, 16);
    twrite('h10, int'($urandom), 16);
    twrite('h11, int'($urandom), 15);
    for (int i = 0; i < 63; i++) send('h10, 1'b0, 1'b1);
    send('h11, 1'b0, 1'b1);
    send('h00, 1'b1, 1'b0);
    wait_fin(2000);
    chk("ovf_total", int'(total_bit_o), 1024);
    chk("ovf_flag", int'(overflow_o), 1);
    chk("ovf_strobes", strobes, 1024);
    chk("ovf_finish", int'(finish_o), 1);

    // Reset mid-shift.
    clr();
    twrite('h20, int'($urandom), 8);
    send('h20, 1'b0, 1'b0);
    repeat (4) tick();
    do_reset();
    @(negedge clk_i);
    chk("t5_valid", int'(bit_valid_o), 0);
    chk("t5_total", int'(total_bit_o), 0);
    chk("t5_ready", int'(sym_ready_o), 1);
    repeat (10) tick();
    chk("t5_no_strobes", obs_q.size(), 0);
    send('h20, 1'b1, 1'b0);
    wait_fin(100);
    chk("t5_error", int'(error_o), 1);
    chk("t5_total_after", int'(total_bit_o), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/code_serializer.md
Name: code_serializer

Overview:
Upstream neighbour of the bit-store stage. Accepts one symbol per handshake and looks up its Huffman codeword in a local code table. Shifts the codeword out MSB-first, one bit per cycle, as a serial bit stream with a bit strobe. Raises a held finish flag after the last symbol, so the bit store can pack and transmit the stream.

Parameters:
MAX_SYM, 255, highest symbol value; table depth is MAX_SYM+1
BIT_WIDTH, 8, symbol width
CODE_LEN, 16, maximum codeword length in bits
LEN_WIDTH, 5, width of the code-length field (must hold CODE_LEN)
MAX_TEXT, 1024, bit budget of the downstream store

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
clear_i  in  1  pulse; ends a message, returns to IDLE, table kept
tbl_we_i  in  1  code-table write enable
tbl_addr_i  in  BIT_WIDTH  table write address (symbol)
tbl_code_i  in  CODE_LEN  codeword, right-aligned
tbl_len_i  in  LEN_WIDTH  codeword length, 0 = unused symbol
sym_valid_i  in  1  symbol valid
sym_ready_o  out  1  symbol ready
sym_i  in  BIT_WIDTH  symbol
sym_last_i  in  1  marks final symbol of the message
bit_o  out  1  serial code bit (to store text_i)
bit_valid_o  out  1  bit strobe (to store receive_i)
finish_o  out  1  message complete, held (to store finish_i)
total_bit_o  out  11  count of bits emitted this message
overflow_o  out  1  sticky: bit budget MAX_TEXT exceeded
error_o  out  1  sticky: symbol with len 0 was presented

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values:
  - state IDLE; bit_o=0, bit_valid_o=0, finish_o=0, total_bit_o=0, overflow_o=0, error_o=0.
  - All table length fields cleared to 0; code fields are don't-care.
  - sym_ready_o=1 in the cycle after reset releases.
- rst_i mid-message aborts immediately. Nothing is emitted on the edge where rst_i is sampled high.
- Table writes are honoured only in IDLE and FINISH; ignored in LOOKUP and SHIFT. Write and read are synchronous; read data is registered (one-cycle latency).
- States: IDLE, LOOKUP, SHIFT, FINISH.
- IDLE:
  - sym_ready_o=1.
  - On sym_valid_i&&sym_ready_o: latch sym_i and sym_last_i, issue table read, go LOOKUP.
  - sym_ready_o=0 in every other state.
- LOOKUP (1 cycle): load shift reg <= code, cnt <= len.
  - len==0: set error_o; go FINISH if last, else IDLE.
  - Otherwise go SHIFT.
- SHIFT:
  - bit_valid_o=(state==SHIFT) and bit_o=shreg[cnt-1], both decoded from registers only. No comb path from inputs.
  - Each cycle: cnt<=cnt-1, total_bit_o<=total_bit_o+1.
  - When cnt==1: go FINISH if last, else IDLE.
- Timing: the accept edge is E0. Bits appear on len consecutive cycles starting the cycle after E1. sym_ready_o returns the cycle after the last bit. Throughput is len+2 cycles per symbol.
- Budget:
  - If total_bit_o==MAX_TEXT while in SHIFT, bit_valid_o is forced 0, overflow_o is set, and total_bit_o saturates.
  - The remaining bits are dropped but the state sequence is unchanged.
- FINISH: finish_o=1 held; bit_valid_o=0. Exits only on clear_i (to IDLE) or rst_i.
- clear_i:
  - Honoured in any state; rst_i wins if both are high.
  - Next state IDLE; finish_o, total_bit_o, overflow_o, error_o cleared; table kept.
- MSB-first rule: the first bit emitted is code[len-1], the last is code[0]. Bits above len-1 are ignored.
- Width rules: total_bit_o is 11 bits so it can hold 1024. cnt is LEN_WIDTH bits. tbl_len_i > CODE_LEN is clamped to CODE_LEN.

Decomposition:
- Shared package huff_pkg:
  - ser_state_e enum {IDLE, LOOKUP, SHIFT, FINISH}, logic [1:0].
  - Constants MAX_TEXT=1024, TOTAL_W=11.
  - Shared defaults for BIT_WIDTH, CODE_LEN, LEN_WIDTH.
- Sub-module code_table: (MAX_SYM+1)-entry RAM of {len, code} with sync write, registered read, and synchronous clear of the len fields on rst_i.
- The FSM, shifter and counters stay in code_serializer.

Test Plan:
- Reset, write sym 0x41 = code 3'b101 len 3, send 0x41 with last=1 -> bit_valid_o high 3 cycles with bits 1,0,1 starting the cycle after E1; finish_o=1 held; total_bit_o=3.
- Write 0x41 = 1'b0/1, 0x42 = 2'b11/2; send 0x41, 0x42, 0x41 (last), sym_valid_i held high -> stream 0,1,1,0; sym_ready_o low during LOOKUP/SHIFT; total_bit_o=4.
- Write 0x00 = 16'hFFFF len 16; send 1023 bits worth of symbols then 0x00 -> exactly 1024 strobes; overflow_o=1; total_bit_o=1024; finish_o still asserts.
- Send an unwritten symbol 0x7F (len 0) with last=0, then a valid symbol -> no strobe for 0x7F; error_o=1; the next symbol emits normally.
- Assert rst_i during SHIFT of a len-8 code -> no further strobes; all outputs at reset values; the old table len fields read back as 0 (next symbol sets error_o).
- In FINISH, pulse clear_i, then send 0x41 last -> total_bit_o restarts at 0 and reaches 3; the table was retained (bits 1,0,1).
